spi_ram_arbiter: RTL and testbench

- Shares the single-port RAM command interface (10-bit frame: din[9:8] command, din[7:0] payload) between the SPI slave receive path and a local host port.
- RAM command encoding: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- RAM address registers are stateful, so the block locks ownership across each address/data frame pair.
- SPI frames cannot be stalled, so they have priority; a 1-deep pending buffer absorbs SPI frames that arrive while the host owns the RAM.

---
 rtl/spi_ram_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares the single-port RAM command interface between the SPI slave
// receive path and a local host port. SPI frames cannot be stalled, so they win
// arbitration; a one-deep pend buffer holds an SPI frame that arrives while the RAM is busy
// with something that cannot be interrupted. Address/data frame pairs are kept atomic by
// holding ownership until the pair completes or a watchdog expires.
module spi_ram_arbiter #(
    parameter int unsigned LOCK_TIMEOUT = 64,
    parameter int unsigned RD_TIMEOUT   = 8
) (
    input  logic       CLK,
    input  logic       rst_n,
    // SPI slave side
    input  logic       spi_rx_valid,
    input  logic [9:0] spi_rx_data,
    output logic       spi_tx_valid,
    output logic [7:0] spi_tx_data,
    // Local host side
    input  logic       host_req,
    input  logic       host_we,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_gnt,
    output logic       host_done,
    output logic       host_rvalid,
    output logic [7:0] host_rdata,
    // RAM command side
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    // Sticky errors: [0] pend overflow, [1] timeout
    output logic [1:0] err_flags
);

    localparam int unsigned MaxTimeout = (LOCK_TIMEOUT > RD_TIMEOUT) ? LOCK_TIMEOUT : RD_TIMEOUT;
    localparam int unsigned CntW       = $clog2(MaxTimeout + 1);

    localparam logic [CntW-1:0] LockLast = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] RdLast   = CntW'(RD_TIMEOUT - 1);

    localparam logic [1:0] CmdWrAddr = 2'b00;
    localparam logic [1:0] CmdWrData = 2'b01;
    localparam logic [1:0] CmdRdAddr = 2'b10;
    localparam logic [1:0] CmdRdData = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StSpiLock,
        StSpiRdWait,
        StHostAddr,
        StHostRdWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_valid_q, pend_valid_d;
    logic [9:0]      pend_data_q, pend_data_d;
    logic            hwe_q, hwe_d;
    logic [7:0]      hwdata_q, hwdata_d;

    logic [9:0]      ram_din_q, ram_din_d;
    logic            ram_rx_valid_q, ram_rx_valid_d;
    logic            spi_tx_valid_q, spi_tx_valid_d;
    logic [7:0]      spi_tx_data_q, spi_tx_data_d;
    logic            host_gnt_q, host_gnt_d;
    logic            host_done_q, host_done_d;
    logic            host_rvalid_q, host_rvalid_d;
    logic [7:0]      host_rdata_q, host_rdata_d;
    logic [1:0]      err_q, err_d;

    // The pend buffer always has priority over a live frame as the SPI source.
    logic            spi_src_valid;
    logic [9:0]      spi_src;
    logic            park_live;

    assign spi_src_valid = pend_valid_q | spi_rx_valid;
    assign spi_src       = pend_valid_q ? pend_data_q : spi_rx_data;

    // States in which the RAM is mid-transaction and a live SPI frame must be parked.
    assign park_live = spi_rx_valid &&
                       (state_q inside {StSpiRdWait, StHostAddr, StHostRdWait});

    // Next-state, counter, pend buffer and registered-output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pend_valid_d   = pend_valid_q;
        pend_data_d    = pend_data_q;
        hwe_d          = hwe_q;
        hwdata_d       = hwdata_q;
        ram_din_d      = 10'h000;
        ram_rx_valid_d = 1'b0;
        spi_tx_valid_d = 1'b0;
        spi_tx_data_d  = 8'h00;
        host_gnt_d     = 1'b0;
        host_done_d    = 1'b0;
        host_rvalid_d  = 1'b0;
        host_rdata_d   = 8'h00;
        err_d          = err_q;

        unique case (state_q)
            StIdle, StSpiLock: begin
                if (spi_src_valid) begin
                    ram_din_d      = spi_src;
                    ram_rx_valid_d = 1'b1;
                    cnt_d          = '0;
                    // A live frame that loses to the pend buffer takes its slot.
                    pend_valid_d   = pend_valid_q & spi_rx_valid;
                    if (pend_valid_q && spi_rx_valid) begin
                        pend_data_d = spi_rx_data;
                    end
                    unique case (spi_src[9:8])
                        CmdWrAddr, CmdRdAddr: state_d = StSpiLock;
                        CmdWrData:            state_d = StIdle;
                        CmdRdData:            state_d = StSpiRdWait;
                        default:              state_d = StIdle;
                    endcase
                end else if (state_q == StIdle) begin
                    if (host_req) begin
                        hwe_d          = host_we;
                        hwdata_d       = host_wdata;
                        host_gnt_d     = 1'b1;
                        ram_din_d      = {host_we ? CmdWrAddr : CmdRdAddr, host_addr};
                        ram_rx_valid_d = 1'b1;
                        state_d        = StHostAddr;
                    end
                end else if (cnt_q == LockLast) begin
                    // SPI master abandoned the pair; release the RAM.
                    err_d[1] = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StSpiRdWait: begin
                if (ram_tx_valid) begin
                    spi_tx_valid_d = 1'b1;
                    spi_tx_data_d  = ram_dout;
                    state_d        = StIdle;
                end else if (cnt_q == RdLast) begin
                    err_d[1] = 1'b1;
                    state_d  = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StHostAddr: begin
                ram_rx_valid_d = 1'b1;
                if (hwe_q) begin
                    ram_din_d   = {CmdWrData, hwdata_q};
                    host_done_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    ram_din_d = {CmdRdData, 8'h00};
                    cnt_d     = '0;
                    state_d   = StHostRdWait;
                end
            end

            StHostRdWait: begin
                if (ram_tx_valid) begin
                    host_rvalid_d = 1'b1;
                    host_rdata_d  = ram_dout;
                    state_d       = StIdle;
                end else if (cnt_q == RdLast) begin
                    // The host still gets its completion, with zero data.
                    err_d[1]      = 1'b1;
                    host_rvalid_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        if (park_live) begin
            if (pend_valid_q) begin
                err_d[0] = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_data_d  = spi_rx_data;
            end
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            pend_valid_q   <= 1'b0;
            pend_data_q    <= 10'h000;
            hwe_q          <= 1'b0;
            hwdata_q       <= 8'h00;
            ram_din_q      <= 10'h000;
            ram_rx_valid_q <= 1'b0;
            spi_tx_valid_q <= 1'b0;
            spi_tx_data_q  <= 8'h00;
            host_gnt_q     <= 1'b0;
            host_done_q    <= 1'b0;
            host_rvalid_q  <= 1'b0;
            host_rdata_q   <= 8'h00;
            err_q          <= 2'b00;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_valid_q   <= pend_valid_d;
            pend_data_q    <= pend_data_d;
            hwe_q          <= hwe_d;
            hwdata_q       <= hwdata_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            spi_tx_valid_q <= spi_tx_valid_d;
            spi_tx_data_q  <= spi_tx_data_d;
            host_gnt_q     <= host_gnt_d;
            host_done_q    <= host_done_d;
            host_rvalid_q  <= host_rvalid_d;
            host_rdata_q   <= host_rdata_d;
            err_q          <= err_d;
        end
    end

    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign spi_tx_valid = spi_tx_valid_q;
    assign spi_tx_data  = spi_tx_data_q;
    assign host_gnt     = host_gnt_q;
    assign host_done    = host_done_q;
    assign host_rvalid  = host_rvalid_q;
    assign host_rdata   = host_rdata_q;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all cross-checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_spi_ram_arbiter;

    localparam int LockTo = 64;
    localparam int RdTo   = 8;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_rx_valid = 1'b0;
    logic [9:0] spi_rx_data = 10'h000;
    logic       spi_tx_valid;
    logic [7:0] spi_tx_data;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_wdata = 8'h00;
    logic       host_gnt;
    logic       host_done;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = 8'h00;
    logic       ram_tx_valid = 1'b0;
    logic [1:0] err_flags;

    always #5 CLK = ~CLK;

    spi_ram_arbiter #(
        .LOCK_TIMEOUT(LockTo),
        .RD_TIMEOUT  (RdTo)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .spi_rx_valid(spi_rx_valid),
        .spi_rx_data (spi_rx_data),
        .spi_tx_valid(spi_tx_valid),
        .spi_tx_data (spi_tx_data),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_done   (host_done),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_din     (ram_din),
        .ram_rx_valid(ram_rx_valid),
        .ram_dout    (ram_dout),
        .ram_tx_valid(ram_tx_valid),
        .err_flags   (err_flags)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // Ownership of the RAM plus an absolute deadline cycle for whichever watchdog applies.
    typedef enum int {OwnNone, OwnSpiPair, OwnSpiRead, OwnHostData, OwnHostRead} owner_e;

    owner_e     m_owner = OwnNone;
    int         m_cyc = 0;
    int         m_deadline = 0;
    logic [9:0] m_pend[$];
    bit         m_hwe = 1'b0;
    logic [7:0] m_hwdata = 8'h00;
    logic [1:0] m_err = 2'b00;

    logic [9:0] e_din = 10'h000;
    logic       e_rxv = 1'b0;
    logic       e_stv = 1'b0;
    logic [7:0] e_std = 8'h00;
    logic       e_gnt = 1'b0;
    logic       e_done = 1'b0;
    logic       e_rv = 1'b0;
    logic [7:0] e_rd = 8'h00;

    wire [32:0] dut_vec = {ram_din, ram_rx_valid, spi_tx_valid, spi_tx_data, host_gnt,
                           host_done, host_rvalid, host_rdata, err_flags};
    wire [32:0] exp_vec = {e_din, e_rxv, e_stv, e_std, e_gnt, e_done, e_rv, e_rd, m_err};

    task automatic m_clear_outputs();
        e_din  = 10'h000;
        e_rxv  = 1'b0;
        e_stv  = 1'b0;
        e_std  = 8'h00;
        e_gnt  = 1'b0;
        e_done = 1'b0;
        e_rv   = 1'b0;
        e_rd   = 8'h00;
    endtask

    task automatic m_spi_forward(input logic [9:0] f);
        e_din = f;
        e_rxv = 1'b1;
        if (f[9:8] == 2'b01) begin
            m_owner = OwnNone;
        end else if (f[9:8] == 2'b11) begin
            m_owner    = OwnSpiRead;
            m_deadline = m_cyc + RdTo;
        end else begin
            m_owner    = OwnSpiPair;
            m_deadline = m_cyc + LockTo;
        end
    endtask

    task automatic m_step();
        logic [9:0] f;
        m_cyc++;
        m_clear_outputs();
        if (m_owner == OwnNone || m_owner == OwnSpiPair) begin
            if (m_pend.size() != 0) begin
                f = m_pend.pop_front();
                if (spi_rx_valid) m_pend.push_back(spi_rx_data);
                m_spi_forward(f);
            end else if (spi_rx_valid) begin
                m_spi_forward(spi_rx_data);
            end else if (m_owner == OwnNone) begin
                if (host_req) begin
                    m_hwe    = host_we;
                    m_hwdata = host_wdata;
                    e_gnt    = 1'b1;
                    e_rxv    = 1'b1;
                    e_din    = {host_we ? 2'b00 : 2'b10, host_addr};
                    m_owner  = OwnHostData;
                end
            end else if (m_cyc == m_deadline) begin
                m_err[1] = 1'b1;
                m_owner  = OwnNone;
            end
        end else begin
            if (spi_rx_valid) begin
                if (m_pend.size() != 0) m_err[0] = 1'b1;
                else m_pend.push_back(spi_rx_data);
            end
            case (m_owner)
                OwnSpiRead: begin
                    if (ram_tx_valid) begin
                        e_stv   = 1'b1;
                        e_std   = ram_dout;
                        m_owner = OwnNone;
                    end else if (m_cyc == m_deadline) begin
                        m_err[1] = 1'b1;
                        m_owner  = OwnNone;
                    end
                end
                OwnHostData: begin
                    e_rxv = 1'b1;
                    if (m_hwe) begin
                        e_din   = {2'b01, m_hwdata};
                        e_done  = 1'b1;
                        m_owner = OwnNone;
                    end else begin
                        e_din      = 10'h300;
                        m_owner    = OwnHostRead;
                        m_deadline = m_cyc + RdTo;
                    end
                end
                default: begin
                    if (ram_tx_valid) begin
                        e_rv    = 1'b1;
                        e_rd    = ram_dout;
                        m_owner = OwnNone;
                    end else if (m_cyc == m_deadline) begin
                        m_err[1] = 1'b1;
                        e_rv     = 1'b1;
                        m_owner  = OwnNone;
                    end
                end
            endcase
        end
    endtask

    // Model advances on every clock edge and collapses on asynchronous reset.
    initial begin
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                m_clear_outputs();
                m_owner = OwnNone;
                m_pend.delete();
                m_err = 2'b00;
            end else begin
                m_step();
            end
        end
    end

    // Compare every output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                checks++;
                if (dut_vec !== exp_vec) begin
                    failures++;
                    $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, dut_vec,
                             exp_vec);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic spi_send(input logic [9:0] f);
        spi_rx_valid = 1'b1;
        spi_rx_data  = f;
        tick();
        spi_rx_valid = 1'b0;
    endtask

    task automatic ram_reply(input logic [7:0] d);
        ram_tx_valid = 1'b1;
        ram_dout     = d;
        tick();
        ram_tx_valid = 1'b0;
    endtask

    task automatic host_start(input bit we, input logic [7:0] a, input logic [7:0] wd);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
    endtask

    int gnt_at;
    int spi_pct[3]  = '{30, 5, 1};
    int host_pct[3] = '{25, 30, 10};
    int ram_pct[3]  = '{20, 15, 5};

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge CLK);
        chk_en = 1'b1;
        #1;
        check("reset_outputs", 64'(dut_vec), 64'(0));
        rst_n = 1'b1;
        tick();

        // SPI write pair
        spi_send(10'h0F0);
        check("spi_wr_addr", 64'({ram_rx_valid, ram_din}), 64'({1'b1, 10'h0F0}));
        check("model_wr_addr", 64'({e_rxv, e_din}), 64'({1'b1, 10'h0F0}));
        repeat (10) tick();
        check("lock_quiet", 64'(ram_rx_valid), 64'(0));
        spi_send(10'h1A5);
        check("spi_wr_data", 64'({ram_rx_valid, ram_din}), 64'({1'b1, 10'h1A5}));
        tick();
        check("spi_wr_pulse_end", 64'({ram_rx_valid, err_flags}), 64'(0));

        // SPI read pair
        spi_send(10'h2F0);
        check("spi_rd_addr", 64'(ram_din), 64'(10'h2F0));
        spi_send(10'h300);
        check("spi_rd_data_frame", 64'(ram_din), 64'(10'h300));
        ram_reply(8'hA5);
        check("spi_tx", 64'({spi_tx_valid, spi_tx_data}), 64'({1'b1, 8'hA5}));
        check("model_spi_tx", 64'({e_stv, e_std}), 64'({1'b1, 8'hA5}));
        check("spi_rd_no_host_rvalid", 64'(host_rvalid), 64'(0));
        tick();
        check("spi_tx_pulse_end", 64'(spi_tx_valid), 64'(0));

        // Host write on an idle bus
        host_start(1'b1, 8'h33, 8'h5C);
        tick();
        check("host_wr_gnt", 64'({host_gnt, ram_rx_valid, ram_din}), 64'({2'b11, 10'h033}));
        host_req = 1'b0;
        tick();
        check("host_wr_data", 64'({host_done, host_gnt, ram_din}), 64'({2'b10, 10'h15C}));

        // Host read
        host_start(1'b0, 8'h10, 8'h00);
        tick();
        check("host_rd_gnt", 64'({host_gnt, ram_din}), 64'({1'b1, 10'h210}));
        host_req = 1'b0;
        tick();
        check("host_rd_frame", 64'({host_done, ram_din}), 64'({1'b0, 10'h300}));
        ram_reply(8'h7E);
        check("host_rvalid", 64'({host_rvalid, host_rdata}), 64'({1'b1, 8'h7E}));

        // Host request blocked by an SPI lock
        spi_send(10'h010);
        check("lock_addr", 64'(ram_din), 64'(10'h010));
        host_start(1'b1, 8'h44, 8'h55);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_gnt_in_lock", 64'(host_gnt), 64'(0));
        end
        spi_send(10'h155);
        check("lock_data", 64'({host_gnt, ram_din}), 64'({1'b0, 10'h155}));
        tick();
        check("gnt_after_lock", 64'({host_gnt, ram_din}), 64'({1'b1, 10'h044}));
        host_req = 1'b0;
        tick();
        check("host_wr_after_lock", 64'({host_done, ram_din}), 64'({1'b1, 10'h155}));

        // Collision with a host read, then pend overflow
        host_start(1'b0, 8'h20, 8'h00);
        tick();
        host_req = 1'b0;
        tick();
        spi_send(10'h0AA);
        check("parked_not_fwd", 64'(ram_rx_valid), 64'(0));
        spi_send(10'h0BB);
        check("overflow_flag", 64'(err_flags[0]), 64'(1));
        ram_reply(8'h11);
        check("collision_rvalid", 64'({host_rvalid, host_rdata, ram_rx_valid}),
              64'({1'b1, 8'h11, 1'b0}));
        tick();
        check("pend_drain", 64'({ram_rx_valid, ram_din}), 64'({1'b1, 10'h0AA}));
        tick();
        check("dropped_frame", 64'(ram_rx_valid), 64'(0));
        spi_send(10'h1CC);
        check("unlock_after_drain", 64'(ram_din), 64'(10'h1CC));

        // Lock timeout, then host granted
        spi_send(10'h011);
        host_start(1'b1, 8'h55, 8'h66);
        gnt_at = -1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 63) check("err1_before_timeout", 64'(err_flags[1]), 64'(0));
            if (k == 64) begin
                check("err1_at_timeout", 64'(err_flags[1]), 64'(1));
                check("model_err1", 64'(m_err[1]), 64'(1));
            end
            if (host_gnt) begin
                gnt_at   = k;
                host_req = 1'b0;
                break;
            end
        end
        check("gnt_cycle_after_timeout", 64'(gnt_at), 64'(65));
        check("timeout_gnt_frame", 64'(ram_din), 64'(10'h055));
        tick();
        check("timeout_host_data", 64'({host_done, ram_din}), 64'({1'b1, 10'h166}));

        // Reset inside the host address phase
        host_start(1'b1, 8'h77, 8'h88);
        tick();
        check("pre_reset_gnt", 64'(host_gnt), 64'(1));
        host_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(dut_vec), 64'(0));
        repeat (2) begin
            tick();
            check("no_done_in_reset", 64'(host_done), 64'(0));
        end
        rst_n = 1'b1;
        tick();
        check("after_reset", 64'({host_done, ram_rx_valid, err_flags}), 64'(0));

        // Randomized traffic at three densities
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 1500; c++) begin
                spi_rx_valid = ($urandom_range(99) < spi_pct[seg]);
                spi_rx_data  = 10'($urandom);
                if (host_req && host_gnt) begin
                    host_req = 1'b0;
                end else if (!host_req && ($urandom_range(99) < host_pct[seg])) begin
                    host_start(1'($urandom), 8'($urandom), 8'($urandom));
                end
                ram_tx_valid = ($urandom_range(99) < ram_pct[seg]);
                ram_dout     = 8'($urandom);
                tick();
            end
        end
        spi_rx_valid = 1'b0;
        host_req     = 1'b0;
        ram_tx_valid = 1'b0;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
